// File: rtl/seg_display_pkg.sv
// seg_display_pkg: shared segment constants and the hex-to-cathode decode table.
package seg_display_pkg;

    typedef logic [6:0] seg_n_t;

    localparam seg_n_t SEG_OFF = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} patterns for nibbles 0..F.
    localparam seg_n_t HEX_SEG_N [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic seg_n_t hex_to_seg_n(input logic [3:0] nibble);
        return HEX_SEG_N[nibble];
    endfunction

endpackage

// File: rtl/seg_hex_decoder.sv
// seg_hex_decoder: combinational nibble to active-low seven-segment pattern.
module seg_hex_decoder
    import seg_display_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg_n
);

    assign o_seg_n = hex_to_seg_n(i_nib);

endmodule

// File: rtl/seg_display_scan.sv
// seg_display_scan: time-multiplexed hex display scanner with frame-boundary loading,
// decimal points, leading-zero blanking, blink and PWM brightness.
module seg_display_scan
    import seg_display_pkg::*;
#(
    parameter int N_DIGITS = 4,
    parameter int DIV_W    = 18,
    parameter int BLINK_W  = 25,
    parameter int BRIGHT_W = 3
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_load,
    input  logic [4*N_DIGITS-1:0] i_number,
    input  logic [N_DIGITS-1:0]   i_dp_mask,
    input  logic [N_DIGITS-1:0]   i_blink_mask,
    input  logic                  i_blank_lz,
    input  logic [BRIGHT_W-1:0]   i_brightness,
    output logic [N_DIGITS-1:0]   o_anode_n,
    output logic [6:0]            o_seg_n,
    output logic                  o_dp_n,
    output logic                  o_pending,
    output logic                  o_frame_done
);

    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);

    logic [DIV_W-1:0]      r_div_cnt;
    logic [BLINK_W-1:0]    r_blink_cnt;
    logic [IDX_W-1:0]      r_idx;
    logic [4*N_DIGITS-1:0] r_act_num, r_pend_num;
    logic [N_DIGITS-1:0]   r_act_dp, r_pend_dp, r_act_blink, r_pend_blink;
    logic                  r_pending, r_frame_done;
    logic [N_DIGITS-1:0]   r_anode_n;
    logic [6:0]            r_seg_n;
    logic                  r_dp_n;

    logic                  w_wrap, w_boundary;
    logic [IDX_W-1:0]      w_sel;
    logic [3:0]            w_nib;
    logic [6:0]            w_seg_n;
    logic [N_DIGITS-1:0]   w_lead_zero;
    logic                  w_lz, w_blink_off, w_pwm_on, w_on;

    assign w_wrap     = &r_div_cnt;
    assign w_boundary = w_wrap && (r_idx == LAST_IDX);
    // Digit 0 sits in the most significant nibble/bit, so index maps to bit position LAST_IDX-index.
    assign w_sel      = LAST_IDX - r_idx;
    assign w_nib      = 4'(r_act_num >> {w_sel, 2'b00});

    always_comb begin : lz_chain
        logic zero;
        zero = 1'b1;
        w_lead_zero = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            zero = zero && (r_act_num[4*(N_DIGITS-1-i) +: 4] == 4'h0);
            w_lead_zero[i] = zero;
        end
    end

    assign w_lz        = i_blank_lz && (r_idx != LAST_IDX) && w_lead_zero[r_idx];
    assign w_blink_off = r_blink_cnt[BLINK_W-1] && r_act_blink[w_sel];
    assign w_pwm_on    = r_div_cnt[DIV_W-1 -: BRIGHT_W] <= i_brightness;
    assign w_on        = !w_lz && !w_blink_off && w_pwm_on;

    seg_hex_decoder u_dec (
        .i_nib   (w_nib),
        .o_seg_n (w_seg_n)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_div_cnt    <= '0;
            r_blink_cnt  <= '0;
            r_idx        <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_div_cnt    <= r_div_cnt + 1'b1;
            r_blink_cnt  <= r_blink_cnt + 1'b1;
            r_frame_done <= w_boundary;
            if (w_wrap)
                r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
        end
    end

    // A load landing on the boundary goes straight to active; otherwise it waits for the next boundary.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_act_num    <= '0;
            r_act_dp     <= '0;
            r_act_blink  <= '0;
            r_pend_num   <= '0;
            r_pend_dp    <= '0;
            r_pend_blink <= '0;
            r_pending    <= 1'b0;
        end else if (i_load && w_boundary) begin
            r_act_num    <= i_number;
            r_act_dp     <= i_dp_mask;
            r_act_blink  <= i_blink_mask;
            r_pending    <= 1'b0;
        end else if (w_boundary && r_pending) begin
            r_act_num    <= r_pend_num;
            r_act_dp     <= r_pend_dp;
            r_act_blink  <= r_pend_blink;
            r_pending    <= 1'b0;
        end else if (i_load) begin
            r_pend_num   <= i_number;
            r_pend_dp    <= i_dp_mask;
            r_pend_blink <= i_blink_mask;
            r_pending    <= 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_anode_n <= '1;
            r_seg_n   <= SEG_OFF;
            r_dp_n    <= 1'b1;
        end else begin
            r_anode_n <= w_on ? ~(N_DIGITS'(1) << w_sel) : '1;
            r_seg_n   <= w_on ? w_seg_n : SEG_OFF;
            r_dp_n    <= w_on ? ~r_act_dp[w_sel] : 1'b1;
        end
    end

    assign o_anode_n    = r_anode_n;
    assign o_seg_n      = r_seg_n;
    assign o_dp_n       = r_dp_n;
    assign o_pending    = r_pending;
    assign o_frame_done = r_frame_done;

endmodule

// File: doc/seg_display_scan.md
Name: seg_display_scan

Overview:
- Parametrised successor to the board's 4-digit 7-segment scanner. Time-multiplexes N_DIGITS hex digits onto a common-anode display.
- Adds the following over the previous scanner:
  - tear-free frame-boundary loading with a pending flag;
  - per-digit decimal points;
  - leading-zero blanking;
  - per-digit blink;
  - PWM brightness.
- Sits between the calculator datapath and the board pins. Anode, segment and DP outputs come from one register stage, so they are never skewed.

Parameters:
- N_DIGITS, 4, number of digits scanned; digit 0 is leftmost (most significant).
- DIV_W, 18, prescaler width; each digit is active for 2^DIV_W clk cycles.
- BLINK_W, 25, free-running blink counter width; blink phase = counter MSB.
- BRIGHT_W, 3, brightness control width.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- load  in  1  single-cycle strobe; captures number/dp_mask/blink_mask
- number  in  4*N_DIGITS  hex nibbles; bits [4*N_DIGITS-1 -: 4] = digit 0
- dp_mask  in  N_DIGITS  1 = light DP of digit i (bit N_DIGITS-1 = digit 0)
- blink_mask  in  N_DIGITS  1 = digit blinks (same bit order)
- blank_lz  in  1  enable leading-zero blanking (live, not latched)
- brightness  in  BRIGHT_W  duty level; all-ones = full on
- anode_n  out  N_DIGITS  active-low digit enables, registered
- seg_n  out  7  active-low cathodes {g,f,e,d,c,b,a}, registered
- dp_n  out  1  active-low decimal point, registered
- pending  out  1  load captured, not yet displayed
- frame_done  out  1  1-cycle pulse at each frame boundary

Behaviour:
- Reset (reset=0, async): the following all clear to 0: div_cnt, blink_cnt, digit index, active and pending registers, pending, frame_done. Outputs go to anode_n = all 1, seg_n = 7'h7F, dp_n = 1. The first digit is driven 1 cycle after reset release.
- Prescaler: div_cnt increments every cycle. On wrap (all ones→0), digit index advances i→i+1, and N_DIGITS-1→0.
- Frame boundary: the cycle where div_cnt wraps while index = N_DIGITS-1.
  - frame_done is registered high the cycle after the boundary.
- Load/pending:
  - load=1 captures the inputs into the pending registers and sets pending.
  - At a frame boundary with pending=1, pending registers copy to active and pending clears.
  - load on a boundary cycle bypasses: inputs go straight to active, and pending stays 0.
  - A second load before the boundary overwrites pending (last wins).
- Output stage (per cycle, computed from the current index and div_cnt, registered once):
  - nib = active nibble[index].
  - seg_n = hex decode of nib, using the standard 0-F patterns: 0=7'h40, 1=7'h79, 8=7'h00, F=7'h0E.
  - dp_n = ~active_dp[index].
  - Digit on = NOT(lz_blank) AND NOT(blink_off) AND pwm_on.
  - If on: anode_n = one-hot-low at index; otherwise all ones, with seg_n = 7'h7F and dp_n = 1.
- lz_blank: blank_lz=1, index < N_DIGITS-1, and nibbles 0..index are all zero. The rightmost digit is never LZ-blanked. An LZ-blanked digit also suppresses its DP.
- blink_off: blink_cnt MSB = 1 and active_blink[index] = 1.
- pwm_on: div_cnt[DIV_W-1 -: BRIGHT_W] <= brightness.
  - Duty = (brightness+1)/2^BRIGHT_W.
  - The digit is on at the start of its slot.
- Brightness, blank_lz and the mid-frame index advance take effect on the next cycle. Active data never changes mid-frame.
- Reset mid-operation: immediate blank. pending and the loaded data are discarded.

Decomposition:
- Package seg_display_pkg holds:
  - SEG_OFF = 7'h7F;
  - the 16-entry hex→segment constant table;
  - function hex_to_seg_n(nibble).
- One sub-module, seg_hex_decoder: combinational nibble→seg_n, instantiated once in front of the output register.
- Everything else stays in seg_display_scan.

Test Plan (sim with N_DIGITS=4, DIV_W=4, BLINK_W=8, BRIGHT_W=2):
- Reset/first frame: reset=0 then 1, with brightness=3 and no load.
  - Required: anode_n sequence 1110 is not shown first. Digit 0 gets anode_n=0111 with seg_n=7'h40 for 16 cycles, then 1011, 1101, 1110.
  - frame_done pulses every 64 cycles.
- Tear-free load: load number=16'h12AF, dp_mask=4'b0010 mid-frame at index 1.
  - Required: pending=1 and the display still shows 0000 until the boundary. Next frame shows 1,2,A(7'h08),F(7'h0E); dp_n=0 only on digit 2.
  - pending=0 after the boundary.
- Load coincident with boundary: pulse load exactly on the wrap cycle with number=16'h0003.
  - Required: the following frame shows it, and pending never rises.
- Leading-zero blanking: number=16'h0005, blank_lz=1.
  - Required: digits 0-2 have anode_n=1111 and seg_n=7'h7F; digit 3 shows 7'h12.
  - number=16'h0000: only digit 3 is lit, showing 7'h40.
- Blink + PWM: blink_mask=4'b1000, brightness=1.
  - Required: digit 0 is dark whenever blink_cnt[7]=1. Each lit digit has anode low for exactly 8 of 16 cycles, at the slot start.
- Async reset mid-frame: drop reset while index=2 with pending=1.
  - Required: outputs blank in the same cycle, with no clock needed. After release, pending=0 and the display shows 0000.
